avalon_input_pio_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for board switches/buttons: N-bit input, metastability sync,

---
 rtl/avalon_input_pio_irq_if.sv | 26 ++
 rtl/avalon_input_pio_irq.sv | 145 ++++++++++++++
 tb/tb_avalon_input_pio_irq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_input_pio_irq_if.sv
// Avalon-MM slave bus bundle shared by the input PIO and its bus master.
// Combinational bundle; no storage, no backpressure (fixed-latency slave).
// Single-word bus: 2-bit word address, 32-bit data, no waitrequest.
interface avalon_input_pio_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_input_pio_irq.sv
// Avalon-MM input PIO: synchronised inputs, edge capture (W1C), per-bit IRQ mask, level irq.
// Latency: readdata 1 cycle; in_port to edge_capture SYNC_STAGES+1 cycles (+debounce time if enabled).
// Backpressure: none, slave always accepts. Optional debounce: `define AVALON_INPUT_PIO_DEBOUNCE_EN.
module avalon_input_pio_irq #(
    parameter int              WIDTH           = 8,
    parameter int              EDGE_TYPE       = 0,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_MASK     = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_input_pio_irq_if.slave   bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 2) begin : g_param_err
        $error("avalon_input_pio_irq: parameter out of range");
    end

    if (WIDTH < 32) begin : g_wd_upper
        logic unused_wd_upper;
        assign unused_wd_upper = &{1'b0, bus.writedata[31:WIDTH]};
    end

    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_last;
    logic [WIDTH-1:0]                  stable;
    logic [WIDTH-1:0]                  prev;
    logic [2:0]                        prime_cnt;
    logic                              primed;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  detect;
    logic [WIDTH-1:0]                  edge_capture;
    logic [WIDTH-1:0]                  irq_mask;
    logic [WIDTH-1:0]                  capture_clr;
    logic                              wr_en;
    logic [31:0]                       rd_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];

    // A bit moves to stable only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_last[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    stable[i] <= sync_last[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign stable = sync_last;
`endif

    // Priming hides the reset-to-input transient so levels present at release are not seen as edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            prev <= stable;
            if (prime_cnt != PRIME_DONE) begin
                prime_cnt <= prime_cnt + 3'd1;
            end
        end
    end

    assign primed = (prime_cnt == PRIME_DONE);

    always_comb begin
        edge_raw = stable ^ prev;
        case (EDGE_TYPE)
            1:       edge_raw = stable & ~prev;
            2:       edge_raw = ~stable & prev;
            default: edge_raw = stable ^ prev;
        endcase
        detect = primed ? edge_raw : '0;
    end

    assign wr_en       = bus.chipselect & ~bus.write_n;
    assign capture_clr = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // Detect is OR'd after the clear so a same-cycle edge always survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= RESET_MASK;
        end else begin
            edge_capture <= (edge_capture & ~capture_clr) | detect;
            if (wr_en && bus.address == 2'd2) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        rd_next = '0;
        case (bus.address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_avalon_input_pio_irq.sv
// Bench for avalon_input_pio_irq: vector table plus hand sequences, reads checked via a scoreboard queue.
// Main DUT is 8-bit rising-edge; a 4-bit any-edge DUT shares the bus request lines.
module tb_avalon_input_pio_irq;

    localparam int SYNC = 2;
    localparam int DB   = 16;
`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
    localparam int          LAT      = SYNC + 1 + DB;
    localparam int          RST_WAIT = 40;
    localparam logic [31:0] RST_CAP  = 32'h0000_00FF;
`else
    localparam int          LAT      = SYNC + 1;
    localparam int          RST_WAIT = 10;
    localparam logic [31:0] RST_CAP  = 32'h0000_0000;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in8;
    logic [3:0] in4;
    logic       irq8;
    logic       irq4;

    always #5 clk = ~clk;

    avalon_input_pio_irq_if bus8();
    avalon_input_pio_irq_if bus4();

    assign bus4.address    = bus8.address;
    assign bus4.chipselect = bus8.chipselect;
    assign bus4.write_n    = bus8.write_n;
    assign bus4.writedata  = bus8.writedata;

    avalon_input_pio_irq #(
        .WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .RESET_MASK(8'h00)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8), .in_port(in8), .irq(irq8)
    );

    avalon_input_pio_irq #(
        .WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .RESET_MASK(4'h0)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4), .in_port(in4), .irq(irq4)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [7:0]  in_val;
        logic        wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus8.chipselect = 1'b1;
        bus8.write_n    = 1'b0;
        bus8.address    = a;
        bus8.writedata  = d;
        @(negedge clk);
        bus8.chipselect = 1'b0;
        bus8.write_n    = 1'b1;
        bus8.writedata  = '0;
    endtask

    task automatic read_reg(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        bus8.chipselect = 1'b1;
        bus8.write_n    = 1'b1;
        bus8.address    = a;
        sb_q.push_back('{name, exp});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, sel ? bus4.readdata : bus8.readdata, e.exp);
        @(negedge clk);
        bus8.chipselect = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'h0C, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_000C, 1'b1};
        vecs[1]  = '{8'h0C, 1'b1, 2'd3, 32'h0000_0004, 2'd3, 32'h0000_0008, 1'b1};
        vecs[2]  = '{8'h0C, 1'b1, 2'd3, 32'h0000_0008, 2'd3, 32'h0000_0000, 1'b0};
        vecs[3]  = '{8'h0C, 1'b1, 2'd2, 32'h0000_00F0, 2'd2, 32'h0000_00F0, 1'b0};
        vecs[4]  = '{8'hFC, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_00F0, 1'b1};
        vecs[5]  = '{8'h00, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{8'h00, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b1};
        vecs[7]  = '{8'h00, 1'b0, 2'd0, 32'h0000_0000, 2'd2, 32'h0000_00F0, 1'b1};
        vecs[8]  = '{8'h00, 1'b1, 2'd2, 32'hFFFF_FF00, 2'd2, 32'h0000_0000, 1'b0};
        vecs[9]  = '{8'h00, 1'b1, 2'd2, 32'h0000_000F, 2'd3, 32'h0000_00F0, 1'b0};
        vecs[10] = '{8'h01, 1'b0, 2'd0, 32'h0000_0000, 2'd3, 32'h0000_00F1, 1'b1};
        vecs[11] = '{8'h01, 1'b1, 2'd3, 32'h0000_00FF, 2'd3, 32'h0000_0000, 1'b0};
        vecs[12] = '{8'h01, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0001, 1'b0};

        reset_n         = 1'b0;
        in8             = 8'hFF;
        in4             = 4'h0;
        bus8.chipselect = 1'b0;
        bus8.write_n    = 1'b1;
        bus8.address    = 2'd0;
        bus8.writedata  = '0;
        idle(2);
        check("reset_readdata", bus8.readdata, 32'h0);
        check("reset_irq", {31'h0, irq8}, 32'h0);
        reset_n = 1'b1;

        // Input held high through reset release.
        idle(RST_WAIT);
        check("rst_high_irq", {31'h0, irq8}, 32'h0);
        read_reg(1'b0, 2'd3, RST_CAP, "rst_high_capture");
        read_reg(1'b0, 2'd0, 32'h0000_00FF, "rst_high_data");
        read_reg(1'b0, 2'd2, 32'h0000_0000, "rst_mask");
        in8 = 8'h00;
        idle(LAT + 2);
        write_reg(2'd3, 32'hFFFF_FFFF);
        read_reg(1'b0, 2'd3, 32'h0, "clear_all");

        // Rising edge on bit3: capture exactly LAT edges after the input change.
        write_reg(2'd2, 32'h0000_0008);
        in8 = 8'h08;
        repeat (LAT - 1) @(posedge clk);
        #1 check("lat_before", {31'h0, irq8}, 32'h0);
        @(posedge clk);
        #1 check("lat_at", {31'h0, irq8}, 32'h1);
        @(negedge clk);
        read_reg(1'b0, 2'd3, 32'h0000_0008, "rise_bit3");
        in8 = 8'h00;
        idle(LAT + 2);
        read_reg(1'b0, 2'd3, 32'h0000_0008, "fall_ignored");
        write_reg(2'd3, 32'h0000_00FF);
        read_reg(1'b0, 2'd3, 32'h0, "clear_bit3");

        foreach (vecs[i]) begin
            in8 = vecs[i].in_val;
            idle(LAT + 2);
            if (vecs[i].wr) write_reg(vecs[i].wa, vecs[i].wd);
            read_reg(1'b0, vecs[i].ra, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
            check($sformatf("vec%0d_irq", i), {31'h0, irq8}, {31'h0, vecs[i].exp_irq});
        end

        // Clear and detect on bit0 in the same cycle.
        in8 = 8'h00;
        idle(LAT + 2);
        write_reg(2'd2, 32'h0000_0001);
        in8 = 8'h01;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        write_reg(2'd3, 32'h0000_0001);
        read_reg(1'b0, 2'd3, 32'h0000_0001, "set_wins");
        check("set_wins_irq", {31'h0, irq8}, 32'h1);
        write_reg(2'd3, 32'h0000_0001);
        read_reg(1'b0, 2'd3, 32'h0, "clear_after");

        // Narrow instance: upper bits zero, any-edge capture.
        write_reg(2'd3, 32'hFFFF_FFFF);
        write_reg(2'd2, 32'hFFFF_FFFF);
        read_reg(1'b1, 2'd2, 32'h0000_000F, "w4_mask_upper");
        in4 = 4'h5;
        idle(LAT + 2);
        read_reg(1'b1, 2'd3, 32'h0000_0005, "w4_any_rise");
        write_reg(2'd3, 32'h0000_000F);
        in4 = 4'h1;
        idle(LAT + 2);
        read_reg(1'b1, 2'd3, 32'h0000_0004, "w4_any_fall");

`ifdef AVALON_INPUT_PIO_DEBOUNCE_EN
        write_reg(2'd3, 32'hFFFF_FFFF);
        in8 = 8'h21;
        idle(10);
        in8 = 8'h01;
        idle(LAT + 20);
        read_reg(1'b0, 2'd3, 32'h0, "db_short_glitch");
        in8 = 8'h21;
        idle(20);
        in8 = 8'h01;
        idle(LAT + 20);
        read_reg(1'b0, 2'd3, 32'h0000_0020, "db_long_pulse");
`endif

        // Asynchronous reset in the middle of operation.
        write_reg(2'd3, 32'hFFFF_FFFF);
        write_reg(2'd2, 32'h0000_00FF);
        in8 = 8'h03;
        idle(LAT + 2);
        check("pre_reset_irq", {31'h0, irq8}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_irq", {31'h0, irq8}, 32'h0);
        check("async_reset_rd", bus8.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        read_reg(1'b0, 2'd2, 32'h0, "post_reset_mask");
        read_reg(1'b0, 2'd3, 32'h0, "post_reset_capture");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
